// File: rtl/dst_reg_pipe.sv
// dst_reg_pipe
//   Destination-register selector and tracking pipeline for the MIPS core.
//   Each cycle one of NSEL candidate write addresses is chosen by sel. The
//   choice is gated by we_in and registered into stage 0, and then carried
//   down DEPTH stages. Two decode source addresses are compared against
//   every stage, which gives per-stage hit vectors for forwarding and stall
//   logic.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high; clears every stage
//   cand      NSEL candidate addresses, candidate i at [i*AW +: AW]
//   sel       candidate index; out-of-range values pick the last candidate
//   we_in     decoded instruction writes a register
//   stall     decode stalled; a bubble enters stage 0
//   flush     kill the instruction entering stage 0
//   src_a     decode source address A (rs)
//   src_b     decode source address B (rt)
//   stg_addr  stage k address at [k*AW +: AW]
//   stg_we    stage k write-enable
//   hit_a     src_a matches a live write in stage k
//   hit_b     src_b matches a live write in stage k
module dst_reg_pipe #(
  parameter int AW    = 5,
  parameter int NSEL  = 3,
  parameter int SELW  = 2,
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NSEL*AW-1:0]    cand,
  input  logic [SELW-1:0]       sel,
  input  logic                  we_in,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [AW-1:0]         src_a,
  input  logic [AW-1:0]         src_b,
  output logic [DEPTH*AW-1:0]   stg_addr,
  output logic [DEPTH-1:0]      stg_we,
  output logic [DEPTH-1:0]      hit_a,
  output logic [DEPTH-1:0]      hit_b
);

  logic [AW-1:0]              pick;
  logic                       ent_we;
  logic [AW-1:0]              ent_addr;

  logic [DEPTH-1:0][AW-1:0]   addr_q, addr_d;
  logic [DEPTH-1:0]           we_q, we_d;

  // The last candidate is the default. Unused sel encodings therefore
  // resolve to a defined value and cannot propagate X.
  always_comb begin
    pick = cand[(NSEL-1)*AW +: AW];
    for (int i = 0; i < NSEL - 1; i++) begin
      if (sel == SELW'(i)) pick = cand[i*AW +: AW];
    end
  end

  // A write to $0 is turned into a bubble. This keeps the rule that an
  // address is zero exactly when its stage holds no live write.
  always_comb begin
    ent_we   = we_in && (pick != '0);
    ent_addr = ent_we ? pick : '0;
  end

  // Downstream stages always advance. A stall only affects what enters
  // stage 0.
  always_comb begin
    addr_d = addr_q;
    we_d   = we_q;
    for (int k = 1; k < DEPTH; k++) begin
      addr_d[k] = addr_q[k-1];
      we_d[k]   = we_q[k-1];
    end
    if (stall || flush) begin
      addr_d[0] = '0;
      we_d[0]   = 1'b0;
    end else begin
      addr_d[0] = ent_addr;
      we_d[0]   = ent_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      we_q   <= '0;
    end else begin
      addr_q <= addr_d;
      we_q   <= we_d;
    end
  end

  // A source of $0 never hits. $0 is hard-wired and never forwarded.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit_a[k] = we_q[k] && (addr_q[k] == src_a) && (src_a != '0);
      hit_b[k] = we_q[k] && (addr_q[k] == src_b) && (src_b != '0);
    end
  end

  assign stg_addr = addr_q;
  assign stg_we   = we_q;

endmodule

// File: tb/tb_dst_reg_pipe.sv
module tb_dst_reg_pipe;
  localparam int AW = 5, NSEL = 3, SELW = 2, DEPTH = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [AW-1:0]        c [NSEL];
  logic [NSEL*AW-1:0]   cand;
  logic [SELW-1:0]      sel;
  logic                 we_in, stall, flush;
  logic [AW-1:0]        src_a, src_b;
  logic [DEPTH*AW-1:0]  stg_addr;
  logic [DEPTH-1:0]     stg_we, hit_a, hit_b;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: for each stage, the register address and write flag.
  int m_addr [DEPTH];
  bit m_we   [DEPTH];

  assign cand = {c[2], c[1], c[0]};

  always #5 clk = ~clk;

  dst_reg_pipe #(.AW(AW), .NSEL(NSEL), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cand(cand), .sel(sel), .we_in(we_in),
    .stall(stall), .flush(flush), .src_a(src_a), .src_b(src_b),
    .stg_addr(stg_addr), .stg_we(stg_we), .hit_a(hit_a), .hit_b(hit_b)
  );

  // Behavioural reference model of the pipeline.
  always @(posedge clk) begin
    int s, p;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_addr[k] <= 0;
        m_we[k]   <= 1'b0;
      end
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        m_addr[k] <= m_addr[k-1];
        m_we[k]   <= m_we[k-1];
      end
      s = int'(sel);
      p = (s < NSEL) ? int'(c[s]) : int'(c[NSEL-1]);
      if (stall || flush || !we_in || p == 0) begin
        m_addr[0] <= 0;
        m_we[0]   <= 1'b0;
      end else begin
        m_addr[0] <= p;
        m_we[0]   <= 1'b1;
      end
    end
  end

  function automatic int stg(input int k);
    return int'(stg_addr[k*AW +: AW]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Compare process: runs on every falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        bit ea, eb;
        ea = m_we[k] && (m_addr[k] == int'(src_a)) && (src_a != 0);
        eb = m_we[k] && (m_addr[k] == int'(src_b)) && (src_b != 0);
        chk($sformatf("stg_addr[%0d]", k), stg(k), m_addr[k]);
        chk($sformatf("stg_we[%0d]", k), int'(stg_we[k]), int'(m_we[k]));
        chk($sformatf("hit_a[%0d]", k), int'(hit_a[k]), int'(ea));
        chk($sformatf("hit_b[%0d]", k), int'(hit_b[k]), int'(eb));
        chk($sformatf("invariant[%0d]", k), int'(stg_we[k]), int'(stg(k) != 0));
      end
    end
  end

  // Inputs are set after the active edge, then the task waits one edge.
  // It returns 2 time units after that edge.
  task automatic step(input int s, input bit w, input bit st, input bit fl);
    sel = SELW'(s); we_in = w; stall = st; flush = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; c[0] = 5'd31; c[1] = 5'd8; c[2] = 5'd9;
    sel = 0; we_in = 1'b1; stall = 1'b0; flush = 1'b0; src_a = 0; src_b = 0;
    @(posedge clk); #2;
    step(0, 1, 0, 0);
    chk_en = 1'b1;
    #2;
    chk("reset_we", int'(stg_we), 0);
    chk("reset_addr", int'(stg_addr), 0);
    chk("reset_hits", int'({hit_a, hit_b}), 0);

    // Select and shift.
    reset = 1'b0; c[0] = 5'd8; c[1] = 5'd9; c[2] = 5'd31;
    step(0, 1, 0, 0); #2 chk("sel0", stg(0), 8);
    step(1, 1, 0, 0); #2 chk("sel1", stg(0), 9);
    step(2, 1, 0, 0); #2 chk("sel2", stg(0), 31);
    chk("stage2_after3", stg(2), 8);
    step(3, 1, 0, 0); #2 chk("sel3_default", stg(0), 31);

    // Writes to $0 and entries without a write.
    c[0] = 5'd0;
    step(0, 1, 0, 0); #2 chk("zero_we", int'(stg_we[0]), 0);
    c[0] = 5'd5;
    step(0, 0, 0, 0); #2 chk("nowrite_addr", stg(0), 0);
    src_a = 5'd5; #1 chk("nowrite_hit", int'(hit_a), 0);
    src_a = 5'd0;

    // Stall and flush.
    c[0] = 5'd7;
    step(0, 1, 0, 0); #2 chk("issue7", stg(0), 7);
    step(0, 1, 1, 0); #2 chk("stall_bubble", stg(0), 0);
    chk("stall_shift", stg(1), 7);
    c[0] = 5'd9;
    step(0, 1, 0, 0); #2 chk("issue9", stg(0), 9);
    step(0, 1, 1, 1); #2 chk("stall_flush", stg(0), 0);
    chk("stall_flush_we", int'(stg_we[0]), 0);

    // Hazard hits.
    c[0] = 5'd4; step(0, 1, 0, 0);
    c[0] = 5'd3; step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    src_a = 5'd3; src_b = 5'd4; #1;
    chk("hit_a_011", int'(hit_a), 3);
    chk("hit_b_100", int'(hit_b), 4);
    src_a = 5'd0; #1 chk("hit_a_src0", int'(hit_a), 0);

    // Reset in the middle of a stream.
    c[0] = 5'd10; step(0, 1, 0, 0);
    c[0] = 5'd11; step(0, 1, 0, 0);
    c[0] = 5'd12; step(0, 1, 0, 0);
    #1 chk("fill", stg(2) * 100 + stg(1) * 10 + stg(0), 10 * 100 + 11 * 10 + 12);
    reset = 1'b1; step(0, 1, 0, 0);
    #1 chk("midreset", int'(stg_addr), 0);
    reset = 1'b0; c[0] = 5'd13; step(0, 1, 0, 0);
    #1 chk("refill", stg(0), 13);

    // Random stimulus, checked by the compare process.
    for (int i = 0; i < 2000; i++) begin
      for (int j = 0; j < NSEL; j++)
        c[j] = ($urandom_range(0, 9) == 0) ? 5'd31 : AW'($urandom_range(0, 7));
      src_a = AW'($urandom_range(0, 7));
      src_b = AW'($urandom_range(0, 7));
      reset = ($urandom_range(0, 49) == 0);
      step($urandom_range(0, 3), $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end
    reset = 1'b0;
    @(posedge clk); #2;
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
